// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: drives the instruction-memory request, owns the IF/ID register
// with a one-entry skid buffer, and handles branch redirects, memory timeouts and misaligned PCs.
module fetch_ctrl #(
    parameter int unsigned MAX_WAIT    = 255,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] pc_in,
    output logic [31:0] next_pc,
    output logic        wpcir,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    output logic        fetch_fault
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StHold,
        StDrain,
        StFault
    } state_e;

    localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] ir_pc_q, ir_pc_d;
    logic        ir_valid_q, ir_valid_d;
    logic [31:0] skid_data_q, skid_data_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [7:0]  wait_q, wait_d;

    logic [7:0]  wait_inc;
    logic        misaligned;

    assign wait_inc   = wait_q + 8'd1;
    assign misaligned = ALIGN_CHECK && (pc_in[1:0] != 2'b00);

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        ir_pc_d     = ir_pc_q;
        ir_valid_d  = ir_valid_q;
        skid_data_d = skid_data_q;
        skid_pc_d   = skid_pc_q;
        tgt_d       = tgt_q;
        wait_d      = 8'd0;
        imem_req    = 1'b0;
        wpcir       = 1'b1;
        next_pc     = branch_taken ? branch_target : (pc_in + 32'd4);

        // Decode consumed the current instruction and nothing new arrives: leave a bubble.
        if (!id_stall) begin
            ir_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
            end

            StFetch: begin
                imem_req = 1'b1;
                if (misaligned) begin
                    state_d    = StFault;
                    ir_valid_d = 1'b0;
                end else if (imem_ready) begin
                    wpcir = 1'b0;
                    if (branch_taken) begin
                        ir_valid_d = 1'b0;
                    end else if (!ir_valid_q || !id_stall) begin
                        ir_d       = imem_rdata;
                        ir_pc_d    = pc_in;
                        ir_valid_d = 1'b1;
                    end else begin
                        skid_data_d = imem_rdata;
                        skid_pc_d   = pc_in;
                        state_d     = StHold;
                    end
                end else if (wait_inc == MaxWait) begin
                    state_d    = StFault;
                    ir_valid_d = 1'b0;
                end else begin
                    wait_d = wait_inc;
                    // Request already in flight: keep address stable and redirect once it lands.
                    if (branch_taken) begin
                        tgt_d   = branch_target;
                        state_d = StDrain;
                    end
                end
            end

            StHold: begin
                if (branch_taken) begin
                    wpcir      = 1'b0;
                    ir_valid_d = 1'b0;
                    state_d    = StFetch;
                end else if (!id_stall) begin
                    ir_d       = skid_data_q;
                    ir_pc_d    = skid_pc_q;
                    ir_valid_d = 1'b1;
                    state_d    = StFetch;
                end
            end

            StDrain: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    wpcir      = 1'b0;
                    ir_valid_d = 1'b0;
                    next_pc    = branch_taken ? branch_target : tgt_q;
                    state_d    = StFetch;
                end else if (wait_inc == MaxWait) begin
                    state_d    = StFault;
                    ir_valid_d = 1'b0;
                end else begin
                    wait_d = wait_inc;
                    if (branch_taken) begin
                        tgt_d = branch_target;
                    end
                end
            end

            StFault: begin
                ir_valid_d = 1'b0;
                next_pc    = pc_in + 32'd4;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            ir_q        <= 32'd0;
            ir_pc_q     <= 32'd0;
            ir_valid_q  <= 1'b0;
            skid_data_q <= 32'd0;
            skid_pc_q   <= 32'd0;
            tgt_q       <= 32'd0;
            wait_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            ir_pc_q     <= ir_pc_d;
            ir_valid_q  <= ir_valid_d;
            skid_data_q <= skid_data_d;
            skid_pc_q   <= skid_pc_d;
            tgt_q       <= tgt_d;
            wait_q      <= wait_d;
        end
    end

    assign imem_addr   = pc_in;
    assign ir          = ir_q;
    assign ir_pc       = ir_pc_q;
    assign ir_valid    = ir_valid_q;
    assign fetch_fault = (state_q == StFault);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: models the PC register and instruction memory, and scores every
// instruction delivered into IF/ID against a queue filled when the memory returns data.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] pc_in;
    logic [31:0] next_pc;
    logic        wpcir;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        fetch_fault;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    assign imem_rdata = imem_ready ? mem_data(imem_addr) : 32'h0;

    fetch_ctrl #(
        .MAX_WAIT   (4),
        .ALIGN_CHECK(1'b1)
    ) u_dut (
        .clk          (clk),
        .resetn       (resetn),
        .pc_in        (pc_in),
        .next_pc      (next_pc),
        .wpcir        (wpcir),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .id_stall     (id_stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .ir           (ir),
        .ir_pc        (ir_pc),
        .ir_valid     (ir_valid),
        .fetch_fault  (fetch_fault)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply inputs for this cycle; 'deliver' means the returned word must reach IF/ID.
    task automatic drive(input logic rdy, input logic stall, input logic br,
                         input logic [31:0] tgt, input logic deliver);
        imem_ready    = rdy;
        id_stall      = stall;
        branch_taken  = br;
        branch_target = tgt;
        if (deliver) sb_q.push_back({mem_data(pc_in), pc_in});
        #1;
    endtask

    // One clock: PC register update, then score a freshly loaded IF/ID entry.
    task automatic tick();
        logic        load;
        logic [31:0] nxt;
        logic        stall_prev;
        logic [63:0] e;
        load       = !wpcir;
        nxt        = next_pc;
        stall_prev = id_stall;
        @(posedge clk);
        #1;
        if (load) pc_in = nxt;
        if (!stall_prev && ir_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_underflow", 32'(ir_valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("ir", ir, e[63:32]);
                check_eq("ir_pc", ir_pc, e[31:0]);
            end
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_wpcir", 32'(wpcir), 32'd1);
        check_eq("rst_ir", ir, 32'd0);
        check_eq("rst_ir_pc", ir_pc, 32'd0);
        check_eq("rst_valid", 32'(ir_valid), 32'd0);
        check_eq("rst_fault", 32'(fetch_fault), 32'd0);
    endtask

    initial begin
        resetn        = 1'b1;
        pc_in         = 32'h0;
        imem_ready    = 1'b0;
        id_stall      = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        #2 resetn = 1'b0;
        #10;
        check_reset_outputs();

        @(posedge clk);
        #1 resetn = 1'b1;
        #1;
        check_eq("idle_req", 32'(imem_req), 32'd0);
        check_eq("idle_wpcir", 32'(wpcir), 32'd1);
        tick();
        check_eq("fetch_req", 32'(imem_req), 32'd1);
        check_eq("fetch_addr", imem_addr, 32'h0);

        // Back-to-back accepts from 0
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
            check_eq("acc_wpcir", 32'(wpcir), 32'd0);
            check_eq("acc_next_pc", next_pc, 32'(i * 4 + 4));
            tick();
            check_eq("acc_valid", 32'(ir_valid), 32'd1);
        end

        // Redirect with data present: data dropped
        drive(1'b1, 1'b0, 1'b1, 32'h40, 1'b0);
        check_eq("br_rdy_next", next_pc, 32'h40);
        check_eq("br_rdy_wpcir", 32'(wpcir), 32'd0);
        tick();
        check_eq("br_rdy_valid", 32'(ir_valid), 32'd0);
        check_eq("br_rdy_addr", imem_addr, 32'h40);

        // Three wait cycles at 0x40
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            check_eq("wait_wpcir", 32'(wpcir), 32'd1);
            check_eq("wait_addr", imem_addr, 32'h40);
            check_eq("wait_req", 32'(imem_req), 32'd1);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("late_wpcir", 32'(wpcir), 32'd0);
        tick();
        check_eq("late_fault", 32'(fetch_fault), 32'd0);

        // Skid: decode stalled when 0x44 returns
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check_eq("skid_wpcir", 32'(wpcir), 32'd0);
        tick();
        check_eq("hold_req", 32'(imem_req), 32'd0);
        check_eq("hold_wpcir", 32'(wpcir), 32'd1);
        check_eq("hold_ir_pc", ir_pc, 32'h40);
        check_eq("hold_valid", 32'(ir_valid), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        check_eq("hold2_ir_pc", ir_pc, 32'h40);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("hold_rel_wpcir", 32'(wpcir), 32'd1);
        tick();
        check_eq("post_hold_req", 32'(imem_req), 32'd1);
        check_eq("post_hold_addr", imem_addr, 32'h48);

        // Bubble when decode drains and memory is slow
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        check_eq("bubble_valid", 32'(ir_valid), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();

        // Redirect while request in flight at 0x4C
        drive(1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
        check_eq("drn_wpcir", 32'(wpcir), 32'd1);
        check_eq("drn_addr", imem_addr, 32'h4C);
        check_eq("drn_next_comb", next_pc, 32'h100);
        tick();
        check_eq("drn_valid", 32'(ir_valid), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("drn_req", 32'(imem_req), 32'd1);
        check_eq("drn_addr2", imem_addr, 32'h4C);
        check_eq("drn_wpcir2", 32'(wpcir), 32'd1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("drn_done_wpcir", 32'(wpcir), 32'd0);
        check_eq("drn_done_next", next_pc, 32'h100);
        tick();
        check_eq("drn_done_valid", 32'(ir_valid), 32'd0);
        check_eq("drn_done_addr", imem_addr, 32'h100);

        // Second branch during drain replaces the latched target
        drive(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h300, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("ovr_next", next_pc, 32'h300);
        tick();
        check_eq("ovr_addr", imem_addr, 32'h300);

        // Branch while holding a skid entry
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'h500, 1'b0);
        check_eq("hbr_wpcir", 32'(wpcir), 32'd0);
        check_eq("hbr_next", next_pc, 32'h500);
        tick();
        check_eq("hbr_valid", 32'(ir_valid), 32'd0);
        check_eq("hbr_req", 32'(imem_req), 32'd1);
        check_eq("hbr_addr", imem_addr, 32'h500);

        // PC wrap
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("wrap_next", next_pc, 32'h0);
        tick();
        check_eq("wrap_addr", imem_addr, 32'h0);

        // Asynchronous reset mid-wait
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        #2 resetn = 1'b0;
        pc_in = 32'h80;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1 resetn = 1'b1;
        #1;
        check_eq("re_idle_req", 32'(imem_req), 32'd0);
        check_eq("re_idle_wpcir", 32'(wpcir), 32'd1);
        tick();
        check_eq("re_fetch_req", 32'(imem_req), 32'd1);
        check_eq("re_fetch_addr", imem_addr, 32'h80);
        for (int i = 0; i < 3; i++) tick();
        check_eq("re_cnt_fault", 32'(fetch_fault), 32'd0);
        check_eq("re_cnt_req", 32'(imem_req), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();

        // Timeout at MAX_WAIT = 4
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        check_eq("to3_fault", 32'(fetch_fault), 32'd0);
        check_eq("to3_req", 32'(imem_req), 32'd1);
        tick();
        check_eq("to4_fault", 32'(fetch_fault), 32'd1);
        check_eq("to4_req", 32'(imem_req), 32'd0);
        check_eq("to4_wpcir", 32'(wpcir), 32'd1);
        check_eq("to4_valid", 32'(ir_valid), 32'd0);
        drive(1'b1, 1'b0, 1'b1, 32'h900, 1'b0);
        check_eq("flt_br_wpcir", 32'(wpcir), 32'd1);
        tick();
        check_eq("flt_sticky", 32'(fetch_fault), 32'd1);
        check_eq("flt_req", 32'(imem_req), 32'd0);

        // Misaligned PC
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        resetn = 1'b0;
        pc_in  = 32'h2;
        #1;
        check_eq("mis_rst_fault", 32'(fetch_fault), 32'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("mis_wpcir", 32'(wpcir), 32'd1);
        tick();
        check_eq("mis_fault", 32'(fetch_fault), 32'd1);
        check_eq("mis_valid", 32'(ir_valid), 32'd0);
        check_eq("mis_req", 32'(imem_req), 32'd0);

        check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
